// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - opcode constants and PC-select type shared by the jump stack unit
package jump_pkg;

  localparam logic [2:0] COND_TYPE    = 3'b100;
  localparam logic [1:0] BZ_FN        = 2'b00;
  localparam logic [1:0] BNZ_FN       = 2'b01;
  localparam logic [3:0] NONCOND_TYPE = 4'b1010;
  localparam logic [4:0] JMP_OP       = 5'b10100;
  localparam logic [4:0] JSB_OP       = 5'b10101;
  localparam logic [5:0] RTS_OP       = 6'b101100;

  typedef struct packed {
    logic plus1;
    logic offset;
    logic cnst;
    logic stack;
  } pc_sel_t;

  localparam pc_sel_t PC_SEL_PLUS1  = pc_sel_t'(4'b1000);
  localparam pc_sel_t PC_SEL_OFFSET = pc_sel_t'(4'b0100);
  localparam pc_sel_t PC_SEL_CONST  = pc_sel_t'(4'b0010);
  localparam pc_sel_t PC_SEL_STACK  = pc_sel_t'(4'b0001);

endpackage

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - circular return-address stack with occupancy and error flags
// JUMP_STACK_ERR_STICKY_EN selects sticky registered error flags instead of single-cycle pulses.
module ret_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [ADDR_W-1:0]          i_push_data,
  output logic [ADDR_W-1:0]          o_ret_addr,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow_err,
  output logic                       o_underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_top_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_evt;
  logic              w_unf_evt;

  assign w_top_idx = r_sp - PTR_W'(1);
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_ovf_evt = i_push & w_full;
  assign w_unf_evt = i_pop & w_empty;

  // Entries are never cleared; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && i_push) begin
      r_mem[r_sp] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + PTR_W'(1);
      if (!w_full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && !w_empty) begin
      r_sp    <= w_top_idx;
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_ret_addr = w_empty ? '0 : r_mem[w_top_idx];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

`ifdef JUMP_STACK_ERR_STICKY_EN
  logic r_ovf_err;
  logic r_unf_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (w_ovf_evt) r_ovf_err <= 1'b1;
      if (w_unf_evt) r_unf_err <= 1'b1;
    end
  end

  assign o_overflow_err  = r_ovf_err;
  assign o_underflow_err = r_unf_err;
`else
  assign o_overflow_err  = w_ovf_evt;
  assign o_underflow_err = w_unf_evt;
`endif

endmodule

// File: rtl/jump_stack_unit.sv
// rtl/jump_stack_unit.sv - ID-stage PC-redirect decode with stall gating over the return stack
// JUMP_STACK_ERR_STICKY_EN (in ret_addr_stack) makes the error flags sticky until reset.
module jump_stack_unit
  import jump_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic [5:0]                 opcode,
  input  logic                       is_equal,
  input  logic [ADDR_W-1:0]          pc_plus1,
  output logic                       sel_PC_src_plus1,
  output logic                       sel_PC_src_offset,
  output logic                       sel_PC_src_const,
  output logic                       sel_PC_src_stack,
  output logic                       flush_PR1,
  output logic [ADDR_W-1:0]          ret_addr,
  output logic [$clog2(DEPTH+1)-1:0] stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  pc_sel_t w_sel;
  logic    w_flush;
  logic    w_push;
  logic    w_pop;
  logic    w_br_taken;

  assign w_br_taken = ((opcode[1:0] == BZ_FN)  &&  is_equal) ||
                      ((opcode[1:0] == BNZ_FN) && !is_equal);

  // A stalled ID stage must neither redirect nor touch the stack.
  always_comb begin
    w_sel   = PC_SEL_PLUS1;
    w_flush = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    if (!stall) begin
      if (opcode[5:3] == COND_TYPE) begin
        if (w_br_taken) begin
          w_sel   = PC_SEL_OFFSET;
          w_flush = 1'b1;
        end
      end else if (opcode[5:2] == NONCOND_TYPE) begin
        w_sel   = PC_SEL_CONST;
        w_flush = 1'b1;
        w_push  = (opcode[5:1] == JSB_OP);
      end else if (opcode == RTS_OP) begin
        w_sel   = PC_SEL_STACK;
        w_flush = 1'b1;
        w_pop   = 1'b1;
      end
    end
  end

  assign sel_PC_src_plus1  = w_sel.plus1;
  assign sel_PC_src_offset = w_sel.offset;
  assign sel_PC_src_const  = w_sel.cnst;
  assign sel_PC_src_stack  = w_sel.stack;
  assign flush_PR1         = w_flush;

  ret_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_addr_stack (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_push          (w_push),
    .i_pop           (w_pop),
    .i_push_data     (pc_plus1),
    .o_ret_addr      (ret_addr),
    .o_count         (stack_count),
    .o_full          (stack_full),
    .o_empty         (stack_empty),
    .o_overflow_err  (overflow_err),
    .o_underflow_err (underflow_err)
  );

endmodule

// File: tb/tb_jump_stack_unit.sv
// tb/tb_jump_stack_unit.sv - directed self-checking bench for jump_stack_unit
module tb_jump_stack_unit;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_BZ  = 6'b100000;
  localparam logic [5:0] OP_BNZ = 6'b100001;
  localparam logic [5:0] OP_JMP = 6'b101000;
  localparam logic [5:0] OP_JSB = 6'b101010;
  localparam logic [5:0] OP_RTS = 6'b101100;
`ifdef JUMP_STACK_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [5:0]        opcode;
  logic              is_equal;
  logic [ADDR_W-1:0] pc_plus1;
  logic              sel_PC_src_plus1, sel_PC_src_offset, sel_PC_src_const, sel_PC_src_stack;
  logic              flush_PR1;
  logic [ADDR_W-1:0] ret_addr;
  logic [3:0]        stack_count;
  logic              stack_full, stack_empty, overflow_err, underflow_err;
  logic [4:0]        sel;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // {plus1, offset, const, stack, flush}
  assign sel = {sel_PC_src_plus1, sel_PC_src_offset, sel_PC_src_const, sel_PC_src_stack, flush_PR1};

  jump_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .opcode            (opcode),
    .is_equal          (is_equal),
    .pc_plus1          (pc_plus1),
    .sel_PC_src_plus1  (sel_PC_src_plus1),
    .sel_PC_src_offset (sel_PC_src_offset),
    .sel_PC_src_const  (sel_PC_src_const),
    .sel_PC_src_stack  (sel_PC_src_stack),
    .flush_PR1         (flush_PR1),
    .ret_addr          (ret_addr),
    .stack_count       (stack_count),
    .stack_full        (stack_full),
    .stack_empty       (stack_empty),
    .overflow_err      (overflow_err),
    .underflow_err     (underflow_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; opcode = OP_NOP; is_equal = 1'b0; pc_plus1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({stack_empty, stack_full, overflow_err, underflow_err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1000", {stack_empty, stack_full, overflow_err, underflow_err});
    end
    n_cmp++;
    if (stack_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", stack_count); end
    n_cmp++;
    if (ret_addr !== 12'h000) begin n_fail++; $display("FAIL reset_ret: got %h expected 000", ret_addr); end
    n_cmp++;
    if (sel !== 5'b10000) begin n_fail++; $display("FAIL reset_sel: got %b expected 10000", sel); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [5];
    logic       eqs [5];
    logic [4:0] exp [5];
    ops = '{OP_BZ, OP_BZ, OP_BNZ, OP_BNZ, OP_JMP};
    eqs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp = '{5'b01001, 5'b10000, 5'b01001, 5'b10000, 5'b00101};
    for (int i = 0; i < 5; i++) begin
      opcode = ops[i]; is_equal = eqs[i];
      #1;
      n_cmp++;
      if (sel !== exp[i]) begin n_fail++; $display("FAIL branch_sel[%0d]: got %b expected %b", i, sel, exp[i]); end
    end
    opcode = OP_NOP; is_equal = 1'b0;
    tick();
    n_cmp++;
    if (stack_count !== 4'd0) begin n_fail++; $display("FAIL branch_count: got %0d expected 0", stack_count); end
  endtask

  task automatic test_jsb_rts();
    opcode = OP_JSB; pc_plus1 = 12'h010;
    #1;
    n_cmp++;
    if (sel !== 5'b00101) begin n_fail++; $display("FAIL jsb_sel: got %b expected 00101", sel); end
    tick();
    n_cmp++;
    if ({stack_count, stack_empty} !== {4'd1, 1'b0}) begin
      n_fail++; $display("FAIL jsb_count: got %0d/%b expected 1/0", stack_count, stack_empty);
    end
    opcode = OP_RTS; pc_plus1 = 12'h000;
    #1;
    n_cmp++;
    if (sel !== 5'b00011) begin n_fail++; $display("FAIL rts_sel: got %b expected 00011", sel); end
    n_cmp++;
    if (ret_addr !== 12'h010) begin n_fail++; $display("FAIL rts_ret: got %h expected 010", ret_addr); end
    tick();
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if ({stack_count, stack_empty} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL rts_count: got %0d/%b expected 0/1", stack_count, stack_empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      opcode = OP_JSB; pc_plus1 = 12'(i);
      tick();
    end
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if ({stack_count, stack_full, overflow_err} !== {4'd8, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL fill: got cnt=%0d full=%b ovf=%b expected 8/1/0", stack_count, stack_full, overflow_err);
    end
    opcode = OP_JSB; pc_plus1 = 12'h009;
    tick();
    n_cmp++;
    if ({stack_count, overflow_err} !== {4'd8, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got cnt=%0d ovf=%b expected 8/1", stack_count, overflow_err);
    end
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if (overflow_err !== STICKY) begin n_fail++; $display("FAIL overflow_after_nop: got %b expected %b", overflow_err, STICKY); end
    for (int k = 1; k <= 8; k++) begin
      opcode = OP_RTS;
      #1;
      n_cmp++;
      if (ret_addr !== 12'(10 - k)) begin n_fail++; $display("FAIL pop_ret[%0d]: got %h expected %h", k, ret_addr, 12'(10 - k)); end
      tick();
    end
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if ({stack_count, stack_empty, underflow_err} !== {4'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL drain: got cnt=%0d empty=%b unf=%b expected 0/1/0", stack_count, stack_empty, underflow_err);
    end
  endtask

  task automatic test_underflow();
    opcode = OP_RTS;
    #1;
    n_cmp++;
    if ({sel, ret_addr} !== {5'b00011, 12'h000}) begin
      n_fail++; $display("FAIL underflow_sel: got %b/%h expected 00011/000", sel, ret_addr);
    end
    tick();
    n_cmp++;
    if ({stack_count, underflow_err} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL underflow: got cnt=%0d unf=%b expected 0/1", stack_count, underflow_err);
    end
    opcode = OP_NOP;
    tick();
    n_cmp++;
    if (underflow_err !== STICKY) begin n_fail++; $display("FAIL underflow_after_nop: got %b expected %b", underflow_err, STICKY); end
  endtask

  task automatic test_stall();
    stall = 1'b1; opcode = OP_JSB; pc_plus1 = 12'h0AB;
    #1;
    n_cmp++;
    if (sel !== 5'b10000) begin n_fail++; $display("FAIL stall_sel: got %b expected 10000", sel); end
    tick();
    n_cmp++;
    if (stack_count !== 4'd0) begin n_fail++; $display("FAIL stall_count: got %0d expected 0", stack_count); end
    stall = 1'b0;
    #1;
    n_cmp++;
    if (sel !== 5'b00101) begin n_fail++; $display("FAIL unstall_sel: got %b expected 00101", sel); end
    tick();
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if ({stack_count, ret_addr} !== {4'd1, 12'h0AB}) begin
      n_fail++; $display("FAIL unstall_push: got %0d/%h expected 1/0ab", stack_count, ret_addr);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      opcode = OP_JSB; pc_plus1 = 12'h100 + 12'(i);
      tick();
    end
    opcode = OP_NOP;
    #1;
    n_cmp++;
    if (stack_count !== 4'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", stack_count); end
    opcode = OP_JSB; pc_plus1 = 12'h1FF; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; opcode = OP_NOP;
    #1;
    n_cmp++;
    if ({stack_count, stack_empty, overflow_err, underflow_err} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got cnt=%0d empty=%b ovf=%b unf=%b expected 0/1/0/0",
                         stack_count, stack_empty, overflow_err, underflow_err);
    end
    n_cmp++;
    if (ret_addr !== 12'h000) begin n_fail++; $display("FAIL mid_reset_ret: got %h expected 000", ret_addr); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jsb_rts();
    test_fill_overflow();
    test_underflow();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_stack_unit.md
Name: jump_stack_unit

Overview:
- Next-generation PC-redirect controller for the pipelined core: decodes branch, jump, JSB and RTS opcodes and drives one-hot PC source selects plus the PR1 flush.
- Integrates a parametrised return-address stack that holds pc_plus1 on JSB and supplies the return target on RTS.
- Adds occupancy and full/empty status, error flags, and stall-gated pointer updates.
- Sits in the ID stage, feeding the PC mux and the IF/ID pipeline register.

Parameters:
- ADDR_W, 12, width of PC and return addresses.
- DEPTH, 8, number of return-stack entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  ID stage stalled; blocks all stack state updates and forces selects to the plus1 default
- opcode  in  6  ID-stage opcode
- is_equal  in  1  register-compare result for BZ/BNZ
- pc_plus1  in  ADDR_W  return address pushed on JSB
- sel_PC_src_plus1  out  1  PC source = PC+1
- sel_PC_src_offset  out  1  PC source = branch offset target
- sel_PC_src_const  out  1  PC source = absolute constant (JMP/JSB)
- sel_PC_src_stack  out  1  PC source = ret_addr
- flush_PR1  out  1  flush the IF/ID register
- ret_addr  out  ADDR_W  top-of-stack value; 0 when empty
- stack_count  out  $clog2(DEPTH+1)  current number of valid entries
- stack_full  out  1  stack_count == DEPTH
- stack_empty  out  1  stack_count == 0
- overflow_err  out  1  a JSB was executed while the stack was full
- underflow_err  out  1  an RTS was executed while the stack was empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sp=0, count=0, error flags=0.
  - Entry memory is not cleared.
  - Outputs after reset: stack_empty=1, stack_full=0, ret_addr=0, stack_count=0.
- Decode is combinational, with zero-cycle latency. The selects are one-hot, and the default is plus1=1 with everything else 0.
  - Conditional type (opcode[5:3]==COND_TYPE):
    - BZ_FN with is_equal=1 -> offset=1, flush=1.
    - BNZ_FN with is_equal=0 -> offset=1, flush=1.
  - Non-conditional type (opcode[5:2]==NONCOND_TYPE) -> const=1, flush=1.
    - JSB (opcode[5:1]==JSB_OP) additionally requests a push.
  - RTS (opcode==RTS_OP) -> stack=1, flush=1, and requests a pop.
- stall=1:
  - All selects take the default (plus1=1, flush=0).
  - No push or pop occurs.
  - Error flags hold.
- Push, when requested and not stalled:
  - At the clk edge: mem[sp] <= pc_plus1 and sp <= sp+1 mod DEPTH.
  - count increments and saturates at DEPTH.
- Push while full (circular overwrite):
  - The oldest entry is overwritten, sp wraps, and count stays at DEPTH.
  - overflow_err is raised.
- Pop, when requested and not stalled:
  - ret_addr = mem[sp-1 mod DEPTH] is presented combinationally in the same cycle.
  - At the edge: sp <= sp-1 and count decrements.
- Pop while empty:
  - ret_addr=0, and the PC redirect still occurs.
  - sp and count are unchanged.
  - underflow_err is raised.
- Push and pop are mutually exclusive by opcode, so no simultaneous case exists.
- Status: stack_full and stack_empty are decoded from the registered count only.
- Reset mid-sequence: reset takes priority over any push or pop in the same cycle.

Optional Feature:
- Macro: JUMP_STACK_ERR_STICKY_EN.
- Defined: overflow_err and underflow_err are registered sticky flags, set on the error event and cleared only by reset.
- Undefined: both flags are combinational single-cycle pulses, asserted in the cycle of the offending JSB/RTS and gated by stall.

Decomposition:
- Package jump_pkg holds the opcode constants:
  - COND_TYPE=3'b100
  - BZ_FN=2'b00
  - BNZ_FN=2'b01
  - NONCOND_TYPE=4'b1010
  - JMP_OP=5'b10100
  - JSB_OP=5'b10101
  - RTS_OP=6'b101100
- jump_pkg also holds a typedef for the one-hot PC-select struct.
- Sub-module ret_addr_stack (parameters ADDR_W and DEPTH) holds the memory, sp, count, full/empty logic and error logic.
- The top level keeps only the decode and the stall gating.

Test Plan:
- Reset, then BZ (6'b100000) with is_equal=1 -> offset=1, flush=1, plus1=0; the same opcode with is_equal=0 -> plus1=1, flush=0.
- JSB with pc_plus1=0x010, then RTS -> ret_addr=0x010, sel_stack=1, flush=1; count goes 0→1→0; stack_empty returns to 1.
- Push 8 JSBs with pc_plus1 0x001..0x008 -> stack_full=1, count=8; a 9th JSB with 0x009 -> overflow_err=1, count=8. Then 8 RTS -> ret_addr sequence 0x009,0x008,…,0x002.
- RTS on an empty stack -> ret_addr=0, sel_stack=1, underflow_err=1, count stays 0. With JUMP_STACK_ERR_STICKY_EN, the flag persists after a following NOP; without it, the flag drops in the next cycle.
- JSB with stall=1 -> plus1=1, flush=0, count unchanged; deassert stall -> push occurs.
- Push 3 entries, assert rst_n=0 in the same cycle as a JSB -> count=0, stack_empty=1, error flags=0.
